// File: rtl/dds_gen.sv
// dds_gen: direct digital synthesiser. A phase accumulator stepped by a tuning
// word feeds a waveform shaper (quarter-wave sine LUT, square, triangle,
// sawtooth) with a programmable phase offset. Data is registered one stage
// after the accumulator.
//
// Optional macro DDS_WRAP_SYNC_EN: retunes are staged in shadow registers and
// applied at the next accumulator wrap for phase-continuous retuning. Without
// the macro, every accepted retune applies on its transfer edge.
//
// Config handshake: a transfer happens on a rising edge where cfg_valid and
// cfg_ready are both high; while cfg_ready is low the request is ignored and
// the master must keep cfg_valid and the payload stable until it is accepted.
module dds_gen #(
  parameter int ACC_W  = 16,
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 8,
  parameter logic [ACC_W-1:0] FTW_RST = {{(ACC_W-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_ftw,
  input  logic [ACC_W-1:0] cfg_off,
  input  logic [1:0]       cfg_mode,
  output logic [OUT_W-1:0] Data,
  output logic             wrap
);

  localparam int QW    = LUT_AW - 2;          // quarter-table address width
  localparam int N     = 2 ** QW;             // quarter-table depth
  localparam int LW    = OUT_W - 1;           // LUT entry width (amplitude < MID)
  localparam int MID_I = 2 ** (OUT_W - 1);
  // Only the top PH_W phase bits feed any shaper.
  localparam int PH_W  = (OUT_W + 1 > LUT_AW) ? OUT_W + 1 : LUT_AW;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  localparam logic [1:0] MODE_SINE = 2'd0;
  localparam logic [1:0] MODE_SQR  = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;

  // Quarter-wave table LUT[k] = round((MID-1)*sin(pi/2*(k+0.5)/N)), built at
  // elaboration with a Taylor series so no math library is needed.
  function automatic logic [N*LW-1:0] build_lut();
    logic [N*LW-1:0] tbl;
    real x, term, s, amp;
    int  q;
    tbl = '0;
    amp = real'(MID_I - 1);
    for (int k = 0; k < N; k++) begin
      x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(N);
      term = x;
      s    = x;
      for (int n = 1; n < 10; n++) begin
        term = -term * x * x / real'((2 * n) * (2 * n + 1));
        s    = s + term;
      end
      q = $rtoi(amp * s + 0.5);
      tbl[k*LW +: LW] = LW'(q);
    end
    return tbl;
  endfunction

  localparam logic [N*LW-1:0] LUT = build_lut();

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_a;
  logic [ACC_W-1:0] off_a;
  logic [1:0]       mode_a;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [PH_W-1:0]  ph;
  logic [1:0]       quad;
  logic [QW-1:0]    idx;
  logic [QW-1:0]    lidx;
  logic [LW-1:0]    lval;
  logic [OUT_W-1:0] tri_t;
  logic [OUT_W-1:0] shape;

  assign sum   = {1'b0, acc} + {1'b0, ftw_a};
  assign carry = en & sum[ACC_W];
  assign ph    = PH_W'((acc + off_a) >> (ACC_W - PH_W));
  assign quad  = ph[PH_W-1 -: 2];
  assign idx   = ph[PH_W-3 -: QW];
  // Odd quarters read the table mirrored: N-1-i is the bitwise inverse of i.
  assign lidx  = quad[0] ? ~idx : idx;
  assign lval  = LUT[int'(lidx)*LW +: LW];
  assign tri_t = ph[PH_W-2 -: OUT_W];

  // Waveform shaper for the current phase and mode.
  always_comb begin
    shape = ph[PH_W-1 -: OUT_W];
    case (mode_a)
      MODE_SINE: shape = quad[1] ? (MID - {1'b0, lval}) : (MID + {1'b0, lval});
      MODE_SQR:  shape = ph[PH_W-1] ? '0 : '1;
      MODE_TRI:  shape = ph[PH_W-1] ? ~tri_t : tri_t;
      default:   shape = ph[PH_W-1 -: OUT_W];
    endcase
  end

  // Accumulator, wrap pulse and output sample register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      wrap <= 1'b0;
      Data <= '0;
    end else begin
      if (en) acc <= sum[ACC_W-1:0];
      wrap <= carry;
      Data <= shape;
    end
  end

`ifdef DDS_WRAP_SYNC_EN
  typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_t;

  cfg_state_t       cfg_state;
  cfg_state_t       cfg_next;
  logic             load_shadow;
  logic             load_active;
  logic [ACC_W-1:0] ftw_s;
  logic [ACC_W-1:0] off_s;
  logic [1:0]       mode_s;

  // Retune state register; CFG_PEND is the pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_state <= CFG_IDLE;
    else     cfg_state <= cfg_next;
  end

  // Accept into the shadow when idle; apply at a carry, or at once when the
  // accumulator cannot wrap (en low or ftw_a zero) so an update never stalls.
  always_comb begin
    cfg_next    = cfg_state;
    load_shadow = 1'b0;
    load_active = 1'b0;
    cfg_ready   = 1'b0;
    case (cfg_state)
      CFG_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          load_shadow = 1'b1;
          cfg_next    = CFG_PEND;
        end
      end
      CFG_PEND: begin
        if (carry || !en || (ftw_a == '0)) begin
          load_active = 1'b1;
          cfg_next    = CFG_IDLE;
        end
      end
      default: cfg_next = CFG_IDLE;
    endcase
  end

  // Shadow registers capture the accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw_s  <= '0;
      off_s  <= '0;
      mode_s <= '0;
    end else if (load_shadow) begin
      ftw_s  <= cfg_ftw;
      off_s  <= cfg_off;
      mode_s <= cfg_mode;
    end
  end

  // Active registers take the staged values on the apply edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw_a  <= FTW_RST;
      off_a  <= '0;
      mode_a <= '0;
    end else if (load_active) begin
      ftw_a  <= ftw_s;
      off_a  <= off_s;
      mode_a <= mode_s;
    end
  end
`else
  assign cfg_ready = 1'b1;

  // Active registers load directly on the transfer edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw_a  <= FTW_RST;
      off_a  <= '0;
      mode_a <= '0;
    end else if (cfg_valid) begin
      ftw_a  <= cfg_ftw;
      off_a  <= cfg_off;
      mode_a <= cfg_mode;
    end
  end
`endif

endmodule

// File: tb/tb_dds_gen.sv
// tb_dds_gen: directed bench for dds_gen at default widths
// (ACC_W=16, LUT_AW=8, OUT_W=8, N=64, FTW_RST=1).
module tb_dds_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_ftw;
  logic [15:0] cfg_off;
  logic [1:0]  cfg_mode;
  logic [7:0]  Data;
  logic        wrap;

  int n_vec = 0;
  int n_err = 0;

  dds_gen dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ftw   (cfg_ftw),
    .cfg_off   (cfg_off),
    .cfg_mode  (cfg_mode),
    .Data      (Data),
    .wrap      (wrap)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_ftw   = '0;
    cfg_off   = '0;
    cfg_mode  = '0;
    rst       = 1'b1;
    @(posedge clk);
    #4;
    rst = 1'b0;
    step();
  endtask

  // One transfer edge, then one idle edge so the update is active in both
  // build flavours (caller keeps en low).
  task automatic cfg_idle(input logic [15:0] ftw, input logic [15:0] off, input logic [1:0] mode);
    cfg_valid = 1'b1;
    cfg_ftw   = ftw;
    cfg_off   = off;
    cfg_mode  = mode;
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    cfg_idle(16'h1000, 16'h0000, 2'd3);
    en = 1'b1;
    repeat (5) step();
    n_vec++;
    if (Data !== 8'h40) begin
      n_err++;
      $display("FAIL pre_reset_data: got %0d expected %0d", Data, 64);
    end
    // Assert reset between edges and look before the next edge.
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (Data !== 8'd0) begin
      n_err++;
      $display("FAIL async_reset_data: got %0d expected 0", Data);
    end
    n_vec++;
    if (wrap !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_wrap: got %0b expected 0", wrap);
    end
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_ready: got %0b expected 1", cfg_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    // Reset mode is sine, ftw=1: 256 samples of shape(acc<256)=130, then 133.
    for (int k = 1; k <= 257; k++) begin
      step();
      if (k == 1 || k == 256) begin
        n_vec++;
        if (Data !== 8'd130) begin
          n_err++;
          $display("FAIL reset_sine_k%0d: got %0d expected 130", k, Data);
        end
      end
      if (k == 257) begin
        n_vec++;
        if (Data !== 8'd133) begin
          n_err++;
          $display("FAIL reset_sine_k257: got %0d expected 133", Data);
        end
      end
    end
    // Sawtooth at ftw=1: Data stays 0 for 256 samples, then 1.
    apply_reset();
    cfg_idle(16'h0001, 16'h0000, 2'd3);
    en = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      step();
      n_vec++;
      if (Data !== ((k == 257) ? 8'd1 : 8'd0)) begin
        n_err++;
        $display("FAIL reset_saw_k%0d: got %0d expected %0d", k, Data, (k == 257) ? 1 : 0);
      end
    end
  endtask

  task automatic test_sawtooth();
    logic [7:0] exp_d;
    logic       exp_w;
    apply_reset();
    cfg_idle(16'h0100, 16'h0000, 2'd3);
    en = 1'b1;
    for (int k = 1; k <= 513; k++) begin
      exp_d = 8'((k - 1) % 256);
      exp_w = ((k % 256) == 0);
      step();
      n_vec++;
      if (Data !== exp_d) begin
        n_err++;
        $display("FAIL saw_data_k%0d: got %0d expected %0d", k, Data, exp_d);
      end
      n_vec++;
      if (wrap !== exp_w) begin
        n_err++;
        $display("FAIL saw_wrap_k%0d: got %0b expected %0b", k, wrap, exp_w);
      end
    end
  endtask

  task automatic test_square_enable();
    logic [15:0] acc_m;
    logic [7:0]  exp_d;
    logic        exp_w;
    apply_reset();
    cfg_idle(16'h1000, 16'h0000, 2'd1);
    acc_m = '0;
    // en dropped for 5 cycles while acc=0xF000, where the next step would wrap.
    for (int i = 0; i < 36; i++) begin
      en    = (i >= 15 && i < 20) ? 1'b0 : 1'b1;
      exp_d = acc_m[15] ? 8'd0 : 8'd255;
      exp_w = en && (acc_m == 16'hF000);
      step();
      n_vec++;
      if (Data !== exp_d) begin
        n_err++;
        $display("FAIL square_data_i%0d: got %0d expected %0d", i, Data, exp_d);
      end
      n_vec++;
      if (wrap !== exp_w) begin
        n_err++;
        $display("FAIL square_wrap_i%0d: got %0b expected %0b", i, wrap, exp_w);
      end
      if (en) acc_m = acc_m + 16'h1000;
    end
  endtask

  task automatic test_sine();
    int         sk[9] = '{1, 5, 9, 16, 17, 33, 48, 49, 65};
    logic [7:0] sv[9] = '{8'd130, 8'd178, 8'd219, 8'd255, 8'd255, 8'd126, 8'd1, 8'd1, 8'd130};
    apply_reset();
    cfg_idle(16'h0400, 16'h0000, 2'd0);
    en = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      step();
      for (int j = 0; j < 9; j++) begin
        if (sk[j] == k) begin
          n_vec++;
          if (Data !== sv[j]) begin
            n_err++;
            $display("FAIL sine_k%0d: got %0d expected %0d", k, Data, sv[j]);
          end
        end
      end
      n_vec++;
      if (wrap !== (k == 64)) begin
        n_err++;
        $display("FAIL sine_wrap_k%0d: got %0b expected %0b", k, wrap, (k == 64));
      end
    end
  endtask

  task automatic test_offset_triangle();
    logic [7:0] exp_d;
    int         n;
    apply_reset();
    cfg_idle(16'h0100, 16'h8000, 2'd3);
    en = 1'b1;
    step();
    n_vec++;
    if (Data !== 8'd128) begin
      n_err++;
      $display("FAIL offset_first: got %0d expected 128", Data);
    end
    step();
    n_vec++;
    if (Data !== 8'd129) begin
      n_err++;
      $display("FAIL offset_second: got %0d expected 129", Data);
    end
    apply_reset();
    cfg_idle(16'h0100, 16'h0000, 2'd2);
    en = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      n = k - 1;
      if (n < 128)      exp_d = 8'(2 * n);
      else if (n < 256) exp_d = 8'(511 - 2 * n);
      else              exp_d = 8'd0;
      step();
      n_vec++;
      if (Data !== exp_d) begin
        n_err++;
        $display("FAIL tri_k%0d: got %0d expected %0d", k, Data, exp_d);
      end
    end
  endtask

`ifdef DDS_WRAP_SYNC_EN
  task automatic test_deferred();
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    exp_q = '{8'd16, 8'd32, 8'd40, 8'd48};
    apply_reset();
    // en low: a pending update applies on the next edge.
    cfg_valid = 1'b1;
    cfg_ftw   = 16'h0000;
    cfg_off   = 16'h0000;
    cfg_mode  = 2'd3;
    step();
    cfg_valid = 1'b0;
    n_vec++;
    if (cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL defer_pend_en0: got %0b expected 0", cfg_ready);
    end
    step();
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL defer_apply_en0: got %0b expected 1", cfg_ready);
    end
    // ftw_a is now 0: a transfer applies on the next edge even with en high.
    en        = 1'b1;
    cfg_valid = 1'b1;
    cfg_ftw   = 16'h1000;
    step();
    cfg_valid = 1'b0;
    n_vec++;
    if (cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL defer_pend_ftw0: got %0b expected 0", cfg_ready);
    end
    step();
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL defer_apply_ftw0: got %0b expected 1", cfg_ready);
    end
    // Running at 0x1000 from acc=0; retune to 0x2000 mid-period at edge 20,
    // and offer an ignored 0x4000 request at edge 25 while pending.
    for (int k = 1; k <= 50; k++) begin
      cfg_valid = (k == 20) || (k == 25);
      cfg_ftw   = (k == 20) ? 16'h2000 : 16'h4000;
      step();
      cfg_valid = 1'b0;
      if (wrap === 1'b1) got_q.push_back(8'(k));
      if (k == 20 || k == 31) begin
        n_vec++;
        if (cfg_ready !== 1'b0) begin
          n_err++;
          $display("FAIL defer_ready_k%0d: got %0b expected 0", k, cfg_ready);
        end
      end
      if (k == 32) begin
        n_vec++;
        if (cfg_ready !== 1'b1) begin
          n_err++;
          $display("FAIL defer_ready_k32: got %0b expected 1", cfg_ready);
        end
      end
      if (k == 34) begin
        n_vec++;
        if (Data !== 8'h20) begin
          n_err++;
          $display("FAIL defer_data_k34: got %0d expected 32", Data);
        end
      end
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL defer_wrap_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        n_vec++;
        if (got_q[j] !== exp_q[j]) begin
          n_err++;
          $display("FAIL defer_wrap_%0d: got edge %0d expected edge %0d", j, got_q[j], exp_q[j]);
        end
      end
    end
  endtask
`else
  task automatic test_back_to_back();
    apply_reset();
    en        = 1'b0;
    cfg_valid = 1'b1;
    cfg_ftw   = 16'h0000;
    cfg_off   = 16'h1000;
    cfg_mode  = 2'd3;
    step();
    n_vec++;
    if (Data !== 8'd130) begin
      n_err++;
      $display("FAIL b2b_first: got %0d expected 130", Data);
    end
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready: got %0b expected 1", cfg_ready);
    end
    cfg_off = 16'h2000;
    step();
    n_vec++;
    if (Data !== 8'h10) begin
      n_err++;
      $display("FAIL b2b_second: got %0d expected 16", Data);
    end
    cfg_off  = 16'h3000;
    cfg_mode = 2'd2;
    step();
    n_vec++;
    if (Data !== 8'h20) begin
      n_err++;
      $display("FAIL b2b_third: got %0d expected 32", Data);
    end
    cfg_valid = 1'b0;
    step();
    n_vec++;
    if (Data !== 8'd96) begin
      n_err++;
      $display("FAIL b2b_tri: got %0d expected 96", Data);
    end
    // ftw_a=0: enabled accumulator stays put and never wraps.
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (Data !== 8'd96 || wrap !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_hold_%0d: got data %0d wrap %0b expected data 96 wrap 0", k, Data, wrap);
      end
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_ftw   = '0;
    cfg_off   = '0;
    cfg_mode  = '0;
    test_reset();
    test_sawtooth();
    test_square_enable();
    test_sine();
    test_offset_triangle();
`ifdef DDS_WRAP_SYNC_EN
    test_deferred();
`else
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dds_gen.md
# dds_gen

Parametrised direct digital synthesiser: a phase accumulator stepped by a programmable frequency tuning word drives a waveform shaper (quarter-wave sine LUT, square, triangle, sawtooth) with a programmable phase offset. It generalises the lab's fixed 8-bit DDS to configurable accumulator, LUT and output widths. It adds a ready/valid configuration port so the waveform generator can be retuned at run time without glitches. It sits between a configuration master (host FSM or switches) and a DAC or the scope/analysis path.

## Interface
- ACC_W, 16: phase accumulator width; must satisfy ACC_W ≥ OUT_W+1 and ACC_W ≥ LUT_AW.
- LUT_AW, 8: phase bits used to address the sine; the quarter table has N = 2^(LUT_AW-2) entries.
- OUT_W, 8: output sample width, unsigned offset-binary.
- FTW_RST, 1: tuning word loaded at reset.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  accumulator advance enable.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration can be accepted.
- cfg_ftw  in  ACC_W  new tuning word.
- cfg_off  in  ACC_W  new phase offset.
- cfg_mode  in  2  new mode: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- Data  out  OUT_W  waveform sample, registered.
- wrap  out  1  one-cycle pulse when the accumulator overflows.

## Operation
- Active registers: ftw_a, off_a, mode_a. Shadow registers: ftw_s, off_s, mode_s, plus a pending flag.
- Accumulator:
  - With en=1: acc ← (acc + ftw_a) mod 2^ACC_W. The carry out sets wrap=1 on that same edge; wrap=0 otherwise.
  - With en=0: acc holds and wrap=0.
- Phase: p = (acc + off_a) mod 2^ACC_W. Let MID = 2^(OUT_W-1).
- Sine:
  - Index i = p[ACC_W-3 -: LUT_AW-2]. LUT[k] = round((MID-1)·sin(π/2·(k+0.5)/N)).
  - The two phase MSBs select the quarter:
    - quarter 00: MID+LUT[i]
    - quarter 01: MID+LUT[N-1-i]
    - quarter 10: MID-LUT[i]
    - quarter 11: MID-LUT[N-1-i]
- Square: p[ACC_W-1]=0 gives 2^OUT_W-1; otherwise 0.
- Triangle: t = p[ACC_W-2 -: OUT_W]. Output is t when p[ACC_W-1]=0, else ~t.
- Sawtooth: p[ACC_W-1 -: OUT_W].
- Config handshake:
  - A transfer occurs on an edge where cfg_valid && cfg_ready.
  - Requests arriving while cfg_ready=0 are ignored and must be held by the master.
- Reset (async, at any time, including mid-update):
  - acc=0, ftw_a=FTW_RST, off_a=0, mode_a=0.
  - Shadow registers and pending cleared.
  - Outputs: Data=0, wrap=0, cfg_ready=1.

## Timing
- Data latency: Data at edge t+1 equals shape(acc(t), off_a(t), mode_a(t)). This is one register after the accumulator.
- The first edge after reset release with en=1 produces Data = shape(0). acc becomes FTW_RST on that same edge.
- Config application depends on the macro (see Configuration).
- Wrap-synchronous apply (macro defined):
  - Transfer edge: shadow registers load, pending=1, cfg_ready=0 from the next cycle.
  - Active registers load from shadow on the first later edge where pending=1 and the accumulator carries. pending clears and cfg_ready=1 on that edge. The increment on that edge still uses the old ftw_a.
  - A wrap coinciding with the transfer edge does not apply the new values; they wait for the next wrap.
  - If pending=1 and (ftw_a==0 or en==0), the values apply on the next edge unconditionally. This prevents deadlock.
- Immediate apply (macro undefined): active registers load on the transfer edge and affect Data from the following edge.
- Width rule: all phase arithmetic is modulo 2^ACC_W; no saturation.

## Configuration
- DDS_WRAP_SYNC_EN defined:
  - Configuration is staged in the shadow registers and applied at the accumulator wrap, giving phase-continuous retuning.
  - cfg_ready deasserts while an update is pending.
- DDS_WRAP_SYNC_EN undefined:
  - Shadow registers and pending are not implemented.
  - cfg_ready is tied to 1 and every accepted request applies on the transfer edge.

## Test plan
All cases use defaults: ACC_W=16, LUT_AW=8, OUT_W=8, N=64.
- Reset: assert rst asynchronously mid-waveform, between clock edges → Data=0, wrap=0, cfg_ready=1 immediately. After release with FTW_RST=1 and sawtooth, Data stays 0 for 256 cycles, then reads 1.
- Sawtooth: mode=3, ftw=0x0100, en=1 → Data = 0,1,2,…,255,0. wrap pulses once every 256 cycles, on the edge where Data's source acc returns to 0.
- Square and enable: mode=1, ftw=0x1000 → Data is 255 for 8 samples, then 0 for 8. Dropping en for 5 cycles freezes Data and holds wrap at 0.
- Sine: mode=0, ftw=0x0400 → sample at acc=0 is 130. Samples at acc=0x3C00 and 0x4000 are both 255. Sample at acc=0x8000 is 126. Period is 64 samples.
- Deferred retune (macro defined): running at ftw=0x1000, transfer ftw=0x2000 mid-period → cfg_ready=0 until the wrap. wrap spacing goes 16 cycles, then 8. A second cfg_valid while pending is ignored. With ftw_a=0, a transfer applies on the next edge.
- Phase offset and triangle: mode=3 with off=0x8000 → the first sample after reset is 128. mode=2 with off=0, ftw=0x0100 → Data ramps 0,2,4,…,254, then 255,253,…,1.
